// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b0;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  localparam inst_addr_t ZeroWord = '0;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_FULL
  } if_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-ROM request/acknowledge handshake between fetch (master) and ROM (slave).
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       rom_ce_o;
  inst_addr_t rom_addr_o;
  inst_t      rom_data_i;
  logic       rom_ack_i;

  modport master (output rom_ce_o, output rom_addr_o, input rom_data_i, input rom_ack_i);
  modport slave  (input rom_ce_o, input rom_addr_o, output rom_data_i, output rom_ack_i);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry pc+inst holding buffer; clear/drain take priority over load.
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       drain,
  input  logic       clear,
  input  inst_addr_t pc_i,
  input  inst_t      inst_i,
  output logic       valid_o,
  output inst_addr_t pc_o,
  output inst_t      inst_o
);

  logic       valid_q, valid_d;
  inst_addr_t pc_q, pc_d;
  inst_t      inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (clear || drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      pc_q    <= ZeroWord;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, ROM handshake, skid buffer, branch/flush redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  inst_addr_t  new_pc,
  input  logic        branch_flag_i,
  input  inst_addr_t  branch_target_addr_i,
  if_fetch_if.master  rom,
  output inst_addr_t  if_pc,
  output inst_t       if_inst,
  output logic        if_valid,
  output logic        stallreq_o
);

  if_state_e  state_q, state_d;
  inst_addr_t pc_q, pc_d, rom_addr_q, rom_addr_d, if_pc_q, if_pc_d;
  inst_t      if_inst_q, if_inst_d;
  logic       rom_ce_q, rom_ce_d, if_valid_q, if_valid_d, kill_q, kill_d;
  logic       buf_load, buf_drain, buf_clear, buf_valid;
  inst_addr_t buf_pc;
  inst_t      buf_inst;

  logic       redirect, slot_free;
  inst_addr_t redirect_pc;

  assign redirect    = flush | branch_flag_i;
  assign redirect_pc = flush ? new_pc : branch_target_addr_i;
  assign slot_free   = !if_valid_q || !stall;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= IF_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ:  if (rom.rom_ack_i && !kill_q && !redirect && !slot_free) state_d = IF_FULL;
      IF_FULL: if (redirect || !stall) state_d = IF_REQ;
      default: state_d = IF_IDLE;
    endcase
  end

  // A ROM request cannot be aborted: a redirect without ack sets kill and the
  // address is held until the ack that gets discarded.
  always_comb begin
    pc_d       = pc_q;
    rom_ce_d   = rom_ce_q;
    rom_addr_d = rom_addr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q & stall;
    kill_d     = kill_q;
    buf_load   = 1'b0;
    buf_drain  = 1'b0;
    buf_clear  = redirect;
    if (flush) if_valid_d = 1'b0;
    unique case (state_q)
      IF_IDLE: begin
        pc_d       = redirect ? redirect_pc : pc_q;
        rom_ce_d   = ChipEnable;
        rom_addr_d = pc_d;
      end
      IF_REQ: begin
        if (rom.rom_ack_i) begin
          if (kill_q || redirect) begin
            kill_d     = 1'b0;
            pc_d       = redirect ? redirect_pc : pc_q;
            rom_ce_d   = ChipEnable;
            rom_addr_d = pc_d;
          end else if (slot_free) begin
            if_pc_d    = rom_addr_q;
            if_inst_d  = rom.rom_data_i;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_STEP;
            rom_addr_d = pc_d;
          end else begin
            buf_load = 1'b1;
            rom_ce_d = ChipDisable;
            pc_d     = pc_q + PC_STEP;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = redirect_pc;
        end
      end
      IF_FULL: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          rom_ce_d   = ChipEnable;
          rom_addr_d = redirect_pc;
        end else if (!stall) begin
          buf_drain  = 1'b1;
          if_pc_d    = buf_pc;
          if_inst_d  = buf_inst;
          if_valid_d = buf_valid;
          rom_ce_d   = ChipEnable;
          rom_addr_d = pc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q       <= RESET_PC;
      rom_ce_q   <= ChipDisable;
      rom_addr_q <= RESET_PC;
      if_pc_q    <= ZeroWord;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      kill_q     <= kill_d;
    end
  end

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .drain   (buf_drain),
    .clear   (buf_clear),
    .pc_i    (rom_addr_q),
    .inst_i  (rom.rom_data_i),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .inst_o  (buf_inst)
  );

  assign rom.rom_ce_o   = rom_ce_q;
  assign rom.rom_addr_o = rom_addr_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;
  assign if_valid       = if_valid_q;
  assign stallreq_o     = !if_valid_q && rom_ce_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: hand-computed expectations checked after each clock edge.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_flag_i;
  logic [31:0] new_pc, branch_target_addr_i;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, stallreq_o;
  int          checks = 0;
  int          errors = 0;

  if_fetch_if rif ();

  if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .flush                (flush),
    .new_pc               (new_pc),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .rom                  (rif),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .if_valid             (if_valid),
    .stallreq_o           (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ce, input logic [31:0] addr,
                         input logic [31:0] pc, input logic [31:0] inst, input logic v,
                         input logic sr);
    chk({tag, ".rom_ce"},   {31'd0, rif.rom_ce_o}, {31'd0, ce});
    chk({tag, ".rom_addr"}, rif.rom_addr_o, addr);
    chk({tag, ".if_pc"},    if_pc, pc);
    chk({tag, ".if_inst"},  if_inst, inst);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".stallreq"}, {31'd0, stallreq_o}, {31'd0, sr});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag_i = 1'b0;
    new_pc = 32'h0; branch_target_addr_i = 32'h0;
    rif.rom_ack_i = 1'b0; rif.rom_data_i = 32'h0;
    step(); step();
    chk_out("reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);

    rst = 1'b1; step();
    chk_out("idle_to_req", 1, 32'h0, 32'h0, 32'h0, 0, 1);

    // single-cycle acks
    rif.rom_ack_i = 1'b1; rif.rom_data_i = 32'h1000_0000; step();
    chk_out("seq0", 1, 32'h4, 32'h0, 32'h1000_0000, 1, 0);
    rif.rom_data_i = 32'h1000_0004; step();
    chk_out("seq4", 1, 32'h8, 32'h4, 32'h1000_0004, 1, 0);
    rif.rom_data_i = 32'h1000_0008; step();
    chk_out("seq8", 1, 32'hC, 32'h8, 32'h1000_0008, 1, 0);

    // ack while output slot held -> buffered, ROM idle for 4 stall cycles
    stall = 1'b1; rif.rom_data_i = 32'h1000_000C; step();
    chk_out("stall0", 0, 32'hC, 32'h8, 32'h1000_0008, 1, 0);
    rif.rom_ack_i = 1'b0; rif.rom_data_i = 32'hDEAD_0000;
    step(); chk_out("stall1", 0, 32'hC, 32'h8, 32'h1000_0008, 1, 0);
    step(); chk_out("stall2", 0, 32'hC, 32'h8, 32'h1000_0008, 1, 0);
    step(); chk_out("stall3", 0, 32'hC, 32'h8, 32'h1000_0008, 1, 0);
    stall = 1'b0; step();
    chk_out("drain", 1, 32'h10, 32'hC, 32'h1000_000C, 1, 0);

    // three-cycle ROM latency on 0x10
    step(); chk_out("lat1", 1, 32'h10, 32'hC, 32'h1000_000C, 0, 1);
    step(); chk_out("lat2", 1, 32'h10, 32'hC, 32'h1000_000C, 0, 1);
    rif.rom_ack_i = 1'b1; rif.rom_data_i = 32'h1000_0010; step();
    chk_out("lat_ack", 1, 32'h14, 32'h10, 32'h1000_0010, 1, 0);

    // branch to 0x100 while 0x14 in flight; delay slot 0x10 kept
    rif.rom_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_addr_i = 32'h100; stall = 1'b1;
    step(); chk_out("br_hold", 1, 32'h14, 32'h10, 32'h1000_0010, 1, 0);
    branch_flag_i = 1'b0; stall = 1'b0; rif.rom_ack_i = 1'b1; rif.rom_data_i = 32'hDEAD_0014;
    step(); chk_out("br_kill", 1, 32'h100, 32'h10, 32'h1000_0010, 0, 1);
    rif.rom_data_i = 32'h1000_0100; step();
    chk_out("br_tgt", 1, 32'h104, 32'h100, 32'h1000_0100, 1, 0);

    // flush coincident with ack
    flush = 1'b1; new_pc = 32'h20; rif.rom_data_i = 32'hDEAD_0104; step();
    chk_out("fl_ack", 1, 32'h20, 32'h100, 32'h1000_0100, 0, 1);
    flush = 1'b0; rif.rom_data_i = 32'h1000_0020; step();
    chk_out("fl_tgt", 1, 32'h24, 32'h20, 32'h1000_0020, 1, 0);

    // reset mid-request, late ack ignored
    rst = 1'b0; rif.rom_ack_i = 1'b0; step();
    chk_out("rst_mid", 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step();
    rst = 1'b1; rif.rom_ack_i = 1'b1; rif.rom_data_i = 32'hDEAD_BEEF; step();
    chk_out("rst_late", 1, 32'h0, 32'h0, 32'h0, 0, 1);
    rif.rom_ack_i = 1'b0; step();
    chk_out("rst_wait", 1, 32'h0, 32'h0, 32'h0, 0, 1);
    rif.rom_ack_i = 1'b1; rif.rom_data_i = 32'h1000_0000; step();
    chk_out("rst_first", 1, 32'h4, 32'h0, 32'h1000_0000, 1, 0);

    // flush without ack to top of address space, then wrap
    rif.rom_ack_i = 1'b0; flush = 1'b1; new_pc = 32'hFFFF_FFFC; step();
    chk_out("fl_kill", 1, 32'h4, 32'h0, 32'h1000_0000, 0, 1);
    flush = 1'b0; rif.rom_ack_i = 1'b1; rif.rom_data_i = 32'hDEAD_0004; step();
    chk_out("fl_drop", 1, 32'hFFFF_FFFC, 32'h0, 32'h1000_0000, 0, 1);
    rif.rom_data_i = 32'h1000_FFFC; step();
    chk_out("wrap", 1, 32'h0, 32'hFFFF_FFFC, 32'h1000_FFFC, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end. Owns the PC and the instruction-ROM request/acknowledge handshake.
- Produces the fetch-side pair (if_pc, if_inst), qualified by if_valid, that the IF/ID pipeline register samples.
- Absorbs variable ROM latency with a one-entry skid buffer.
- Handles branch redirects from ID (MIPS delay-slot semantics) and exception flushes from CTRL.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, byte increment per sequential fetch

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- stall  in  1  IF/ID not consuming this cycle; output slot must hold
- flush  in  1  exception flush from CTRL
- new_pc  in  32  flush target
- branch_flag_i  in  1  taken branch/jump resolved in ID
- branch_target_addr_i  in  32  branch target
- rom_ce_o  out  1  ROM request
- rom_addr_o  out  32  ROM word address; stable while rom_ce_o=1 and no ack
- rom_data_i  in  32  ROM read data; valid when rom_ack_i=1
- rom_ack_i  in  1  ROM completion; arrives 1 or more cycles after rom_ce_o rises
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- if_valid  out  1  output slot holds a live instruction
- stallreq_o  out  1  to CTRL; 1 while if_valid=0 and a request is outstanding

Behaviour:
- All state is registered on posedge clk.
- rst=0 at an edge forces: state=IDLE, pc=RESET_PC, rom_ce_o=0, rom_addr_o=RESET_PC, if_pc=0, if_inst=0, if_valid=0, buffer empty, kill=0. This holds from any state; any in-flight ack is ignored.
- States are IDLE, REQ and FULL.
- IDLE: the first cycle after reset release. Next edge goes to REQ with rom_ce_o=1 and rom_addr_o=pc.
- REQ: rom_ce_o=1. On rom_ack_i, with kill=0:
  - If the output slot is free (if_valid=0 or stall=0), load if_pc=rom_addr_o, if_inst=rom_data_i, if_valid=1. Set pc+=PC_STEP and issue the next request back-to-back at the new pc (stay in REQ).
  - If the output slot is held (if_valid=1 and stall=1), write the data to the buffer, drop rom_ce_o, and go to FULL.
- FULL: rom_ce_o=0. When stall=0, move buffer to output, issue a request at pc, and go to REQ.
- Output slot consumption: if stall=0 and nothing new loads, if_valid goes to 0 at that edge.
- Redirect priority: flush > branch_flag_i > sequential.
- flush=1:
  - if_valid=0, buffer cleared, pc=new_pc.
  - If a request is outstanding without ack this cycle, set kill=1. Hold rom_ce_o and rom_addr_o until the ack (a ROM request cannot be aborted), discard that data, then request new_pc.
  - If ack coincides with flush, discard the data and request new_pc on the next cycle.
  - From FULL, go to REQ at new_pc.
- branch_flag_i=1 (no flush):
  - The output slot is kept; it is the delay slot.
  - Buffer and in-flight or coincident ack data are discarded using the same kill rules as flush. pc=branch_target_addr_i.
- Redirect while stall=1: pc still updates; the output slot is cleared only by flush.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- kill clears on the discarded ack.
- Latency: the instruction appears on the outputs the edge after rom_ack_i when the slot is free.

Decomposition:
- Shared defines: RstEnable (1'b0 for this block), ZeroWord, InstAddrBus, InstBus, ChipEnable/ChipDisable, state encodings IF_IDLE/IF_REQ/IF_FULL.
- One natural sub-module: if_skid_buf (one-entry pc+inst buffer with load/drain/clear).

Test Plan:
- Reset then single-cycle ack every cycle -> rom_addr 0,4,8,12; if_pc follows one cycle after each ack; if_valid stays 1; stallreq_o=0 after the first instruction.
- ROM ack latency 3 cycles -> rom_addr_o stable for 3 cycles, stallreq_o=1 during the wait, if_inst=rom_data_i exactly once per ack.
- stall=1 held 4 cycles while an ack arrives -> outputs frozen, data buffered, rom_ce_o=0. At stall release the buffered pc (e.g. 0x0C) appears next, followed by a request for 0x10.
- branch_flag_i=1, target 0x100, while a request for 0x0C is in flight -> output slot 0x08 kept, 0x0C data discarded at ack, next rom_addr_o=0x100.
- flush=1, new_pc=0x20, coincident with an ack -> if_valid=0 the next cycle, data dropped, next request at 0x20.
- rst=0 asserted mid-request with an ack two cycles later -> all outputs at reset values; the late ack is ignored; first post-reset request is RESET_PC.
